// File: rtl/data_memory_pkg.sv
// Shared types for the pipelined data memory: access sizes, sweep FSM states
// and the response-pipeline record.
package data_memory_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int LANES = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (mem_size_e'(size))
      MEM_BYTE: data = unsigned_ld ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: data = unsigned_ld ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      MEM_WORD: data = word;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// Synthesizable MIPS32 data memory: byte/half/word access, fault detection,
// fixed-latency in-order responses and a post-reset zeroing sweep.
module data_memory_pipelined
  import data_memory_pkg::*;
#(
  parameter int          DEPTH          = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        write_enabled,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        resp_valid,
  output logic        err,
  output logic [31:0] r_data,
  output logic        init_done
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

  function automatic logic [LANES-1:0] lane_enable(input mem_size_e s, input logic [1:0] lane);
    logic [LANES-1:0] en;
    en = '0;
    case (s)
      MEM_BYTE: en = 4'b0001 << lane;
      MEM_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: en = 4'b1111;
      default:  en = '0;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] lane_replicate(input mem_size_e s, input logic [31:0] wd);
    logic [31:0] rep;
    case (s)
      MEM_BYTE: rep = {4{wd[7:0]}};
      MEM_HALF: rep = {2{wd[15:0]}};
      default:  rep = wd;
    endcase
    return rep;
  endfunction

  mem_state_e       state, state_next;
  logic [AW-1:0]    cnt;
  logic [31:0]      mem [DEPTH];

  mem_size_e        sz;
  logic             accept;
  logic             range_err;
  logic             align_err;
  logic             fault;
  logic [31:0]      offset;
  logic [AW-1:0]    idx;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;
  logic [LANES-1:0] be;
  logic [31:0]      wd_rep;
  resp_t            resp_in;
  resp_t            resp_p [LATENCY];

  // Held low while reset is asserted even when the FSM resets straight to READY.
  assign req_ready = (state == READY) && !reset;
  assign init_done = (state == READY) && !reset;
  assign accept    = req_valid && req_ready;

  assign sz      = mem_size_e'(size);
  assign offset  = addr - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign rd_word = mem[idx];
  assign be      = lane_enable(sz, addr[1:0]);
  assign wd_rep  = lane_replicate(sz, w_data);

  always_comb begin
    range_err = (addr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH));
    align_err = 1'b0;
    case (sz)
      MEM_HALF:    align_err = addr[0];
      MEM_WORD:    align_err = |addr[1:0];
      MEM_ILLEGAL: align_err = 1'b1;
      default:     align_err = 1'b0;
    endcase
    fault = range_err || align_err;
  end

  dmem_load_align u_load_align (
    .word        (rd_word),
    .lane        (addr[1:0]),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .data        (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && cnt == CNT_MAX)
      state_next = READY;
  end

  // Storage: sweep zeroing or lane-masked store commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && write_enabled && !fault) begin
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
    end
  end

  always_comb begin
    resp_in       = '0;
    resp_in.valid = accept;
    resp_in.err   = accept && fault;
    resp_in.data  = (accept && !write_enabled && !fault) ? ld_data : 32'h0;
  end

  // Stage p0 captures the aligned load at acceptance; later stages only delay it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) resp_p[i] <= '0;
    end else begin
      resp_p[0] <= resp_in;
      for (int i = 1; i < LATENCY; i++) resp_p[i] <= resp_p[i-1];
    end
  end

  assign resp_valid = resp_p[LATENCY-1].valid;
  assign err        = resp_p[LATENCY-1].err;
  assign r_data     = resp_p[LATENCY-1].data;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench for data_memory_pipelined (DEPTH=16, LATENCY=3): directed
// requests push expected responses; a monitor pops and compares each response.
module tb_data_memory_pipelined;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        write_enabled = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] w_data = 32'h0;
  logic        req_ready, resp_valid, err, init_done;
  logic [31:0] r_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  data_memory_pipelined #(
    .DEPTH          (DEPTH),
    .BASE_ADDR      (32'h0000_0000),
    .LATENCY        (LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .write_enabled (write_enabled),
    .size          (size),
    .unsigned_ld   (unsigned_ld),
    .addr          (addr),
    .w_data        (w_data),
    .resp_valid    (resp_valid),
    .err           (err),
    .r_data        (r_data),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; the request is accepted on the next rising edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_data);
    exp_t e;
    chk("req_ready_at_issue", {31'b0, req_ready}, 32'd1);
    req_valid     = 1'b1;
    write_enabled = we;
    size          = sz;
    unsigned_ld   = uns;
    addr          = a;
    w_data        = wd;
    e.err  = e_err;
    e.data = e_data;
    e.acc  = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, DEPTH);
    chk("init_done_after_sweep", {31'b0, init_done}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_resp: got resp_valid=1 err=%0b r_data=0x%08h, required no response", err, r_data);
            end else begin
              e = exp_q.pop_front();
              chk("resp_err", {31'b0, err}, {31'b0, e.err});
              chk("resp_data", r_data, e.data);
              chk("resp_latency", cyc - e.acc, LAT - 1);
            end
          end
        end
      end
    join_none

    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("sweep_init_done_low", {31'b0, init_done}, 32'd0);
    chk("sweep_req_ready_low", {31'b0, req_ready}, 32'd0);
    // One cycle already spent above.
    begin
      int n;
      n = 1;
      while (req_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("sweep_cycles_first", n, DEPTH);
    end

    // Cleared memory, then store/load lane tests (store followed immediately by loads).
    issue(0, SZ_W, 0, 32'h3C, 32'h0, 0, 32'h0000_0000);
    issue(1, SZ_W, 0, 32'h08, 32'hDEAD_BEEF, 0, 32'h0);
    issue(0, SZ_B, 0, 32'h08, 32'h0, 0, 32'hFFFF_FFEF);
    issue(0, SZ_B, 0, 32'h0B, 32'h0, 0, 32'hFFFF_FFDE);
    issue(0, SZ_B, 1, 32'h0B, 32'h0, 0, 32'h0000_00DE);
    issue(0, SZ_H, 0, 32'h0A, 32'h0, 0, 32'hFFFF_DEAD);
    issue(0, SZ_H, 1, 32'h0A, 32'h0, 0, 32'h0000_DEAD);
    issue(1, SZ_B, 0, 32'h09, 32'hFFFF_FF55, 0, 32'h0);
    issue(0, SZ_W, 0, 32'h08, 32'h0, 0, 32'hDEAD_55EF);
    issue(1, SZ_H, 0, 32'h0E, 32'hFFFF_1234, 0, 32'h0);
    issue(0, SZ_W, 0, 32'h0C, 32'h0, 0, 32'h1234_0000);
    issue(0, SZ_H, 0, 32'h0C, 32'h0, 0, 32'h0000_0000);
    issue(1, SZ_W, 0, 32'h3C, 32'hA5A5_0F0F, 0, 32'h0);
    drain();

    // Four back-to-back loads after an idle gap.
    repeat (2) @(negedge clk);
    issue(0, SZ_W, 0, 32'h08, 32'h0, 0, 32'hDEAD_55EF);
    issue(0, SZ_W, 0, 32'h0C, 32'h0, 0, 32'h1234_0000);
    issue(0, SZ_W, 0, 32'h3C, 32'h0, 0, 32'hA5A5_0F0F);
    issue(0, SZ_B, 1, 32'h09, 32'h0, 0, 32'h0000_0055);
    drain();

    // Faults: no data returned and no storage written.
    issue(0, SZ_W, 0, 32'h06, 32'h0, 1, 32'h0);
    issue(1, SZ_H, 0, 32'h05, 32'hBEEF, 1, 32'h0);
    issue(0, SZ_W, 0, 32'h04, 32'h0, 0, 32'h0);
    issue(1, SZ_X, 0, 32'h08, 32'hFFFF_FFFF, 1, 32'h0);
    issue(0, SZ_W, 0, 32'h08, 32'h0, 0, 32'hDEAD_55EF);
    issue(0, SZ_W, 0, 32'h40, 32'h0, 1, 32'h0);
    issue(1, SZ_W, 0, 32'h40, 32'h1111_2222, 1, 32'h0);
    issue(1, SZ_W, 0, 32'hFFFF_FFFC, 32'h3333_4444, 1, 32'h0);
    issue(0, SZ_W, 0, 32'h00, 32'h0, 0, 32'h0);
    issue(0, SZ_W, 0, 32'h3C, 32'h0, 0, 32'hA5A5_0F0F);
    drain();

    // Reset with two responses in flight: both must be dropped.
    issue(0, SZ_W, 0, 32'h08, 32'h0, 0, 32'hDEAD_55EF);
    issue(0, SZ_W, 0, 32'h0C, 32'h0, 0, 32'h1234_0000);
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("sweep5_req_ready_low", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready("sweep_cycles_restart");

    // The new sweep cleared everything, including the last word.
    issue(0, SZ_W, 0, 32'h08, 32'h0, 0, 32'h0);
    issue(0, SZ_W, 0, 32'h3C, 32'h0, 0, 32'h0);
    issue(0, SZ_W, 0, 32'h0C, 32'h0, 0, 32'h0);
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
